// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush control for the five-stage pipeline with saturating perf counters
module pipeline_hazard_ctrl #(
  parameter int DBITS = 32,
  parameter int RBITS = 4,
  parameter int IMEM_LAT = 1,
  parameter int CNTBITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [RBITS-1:0]   srcA_d,
  input  logic [RBITS-1:0]   srcB_d,
  input  logic               useA_d,
  input  logic               useB_d,
  input  logic [RBITS-1:0]   dstReg_e,
  input  logic               memtoReg_e,
  input  logic               regWrite_e,
  input  logic               mispredict_e,
  input  logic               memReq_m,
  input  logic               memAck,
  output logic               stallF,
  output logic               stallD,
  output logic               stallE,
  output logic               stallM,
  output logic               flushD,
  output logic               flushE,
  output logic               flushM,
  output logic               flushW,
  output logic [1:0]         state,
  output logic [CNTBITS-1:0] stallCount,
  output logic [CNTBITS-1:0] flushCount
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, REDIRECT = 2'd2} state_t;
  state_t cur, nxt, retState, retNext;
  logic [3:0] redirCnt, redirNext;
  logic memWait, loadUse, mispTaken;
  if (DBITS < 1 || IMEM_LAT < 0 || IMEM_LAT > 15) begin : g_badParam
    $error("pipeline_hazard_ctrl: DBITS must be positive and IMEM_LAT within 0..15");
  end
  assign memWait = memReq_m & ~memAck;
  assign loadUse = memtoReg_e & regWrite_e & (dstReg_e != '0) &
                   ((useA_d & (srcA_d == dstReg_e)) | (useB_d & (srcB_d == dstReg_e)));
  assign flushM = 1'b0;
  assign state = cur;
  // Mealy hazard resolution: memory wait beats mispredict beats load-use; outputs quiet in reset
  always_comb begin
    nxt = cur;
    retNext = retState;
    redirNext = redirCnt;
    mispTaken = 1'b0;
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    if (!reset) begin
      if (memWait) begin
        {stallF, stallD, stallE, stallM, flushW} = 5'b11111;
        if (cur != MEM_WAIT) begin
          nxt = MEM_WAIT;
          retNext = (cur == REDIRECT) ? REDIRECT : RUN;
        end
      end else if (cur == MEM_WAIT) begin
        nxt = retState;
      end else if (mispredict_e) begin
        {flushD, flushE} = 2'b11;
        mispTaken = 1'b1;
        redirNext = 4'(IMEM_LAT);
        nxt = (IMEM_LAT > 0) ? REDIRECT : RUN;
      end else if (cur == REDIRECT) begin
        flushD = 1'b1;
        redirNext = redirCnt - 4'd1;
        nxt = (redirCnt == 4'd1) ? RUN : REDIRECT;
      end else if (loadUse) begin
        {stallF, stallD, flushE} = 3'b111;
      end
    end
  end
  // State, redirect countdown and saturating event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= RUN;
      retState <= RUN;
      redirCnt <= '0;
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      cur <= nxt;
      retState <= retNext;
      redirCnt <= redirNext;
      if (stallF && stallCount != '1) stallCount <= stallCount + CNTBITS'(1);
      if (mispTaken && flushCount != '1) flushCount <= flushCount + CNTBITS'(1);
    end
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard controller for the five-stage pipeline. It watches decode sources, the execute-stage destination, branch resolution and the data-memory handshake. Each cycle it drives the stall (hold) and flush (bubble) controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers; flushM feeds the EX/MEM register's flush input, which clears memWrite/regWrite. It also keeps saturating stall and flush event counters for performance debug.

## Interface
- DBITS, 32, datapath width (unused internally, carried for consistency)
- RBITS, 4, register index width
- IMEM_LAT, 1, extra cycles flushD stays high after a redirect (0..15)
- CNTBITS, 32, performance counter width
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- srcA_d, srcB_d  in  RBITS  source registers of instruction in decode
- useA_d, useB_d  in  1  decode instruction actually reads srcA/srcB
- dstReg_e  in  RBITS  destination of instruction in execute
- memtoReg_e, regWrite_e  in  1  execute instruction is a load / writes a register
- mispredict_e  in  1  branch/jal resolved in execute with wrong next PC
- memReq_m  in  1  memory-stage instruction accesses data memory (memtoReg_m | memWrite_m)
- memAck  in  1  data memory completes the access this cycle
- stallF, stallD, stallE, stallM  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- flushD, flushE, flushM, flushW  out  1  insert bubble into IF/ID, ID/EX, EX/MEM, MEM/WB
- state  out  2  FSM state (RUN=0, MEM_WAIT=1, REDIRECT=2)
- stallCount, flushCount  out  CNTBITS  saturating counters

## Operation
- Registered: state, retState (RUN/REDIRECT), redirCnt (4 bits), both counters. All stall/flush outputs are combinational (Mealy) from state and inputs.
- memWait = memReq_m & ~memAck. loadUse = memtoReg_e & regWrite_e & (dstReg_e != 0) & ((useA_d & srcA_d==dstReg_e) | (useB_d & srcB_d==dstReg_e)).
- Priority, highest first: memWait, mispredict_e, loadUse.
- RUN:
  - memWait: stallF/D/E/M=1, flushW=1; next MEM_WAIT, retState=RUN.
  - Else mispredict_e: flushD=1, flushE=1; flushCount++. Next REDIRECT with redirCnt=IMEM_LAT when IMEM_LAT>0, else stay RUN.
  - Else loadUse: stallF=stallD=1, flushE=1 (one bubble); stay RUN.
  - Else all outputs 0.
- MEM_WAIT:
  - memWait: same stalls as on entry, hold state.
  - memAck: all outputs 0 this cycle; next retState. A pending mispredict_e is evaluated in the following cycle (EX was held, so it is still asserted).
- REDIRECT:
  - memWait: stalls as in MEM_WAIT, redirCnt frozen; next MEM_WAIT, retState=REDIRECT.
  - Else mispredict_e: flushD=flushE=1, flushCount++, redirCnt reloaded to IMEM_LAT.
  - Else: flushD=1, redirCnt--; next RUN when redirCnt reaches 1 (i.e. exactly IMEM_LAT cycles in REDIRECT). loadUse is ignored (decode instruction is being flushed).
- A stall and a flush never target the same register in one cycle; the bench must check this.
- stallCount increments on every cycle with stallF=1; flushCount increments per accepted mispredict; both saturate at 2^CNTBITS-1.
- flushM is 0 in all current states. It is reserved for exception squash and tied low.

## Timing
- Reset (async assert, any state): state=RUN, retState=RUN, redirCnt=0, counters=0; all stall/flush outputs 0 while reset is high.
- Hazard response is zero-latency: outputs react in the same cycle as the triggering inputs. State changes on the next rising edge.
- Load-use costs exactly 1 bubble. Mispredict costs 2 + IMEM_LAT fetch slots. A memory wait of N cycles without ack adds N stall cycles.
- memAck without memReq_m is ignored. memReq_m with memAck in the same cycle costs no stall.
- Reset deasserting mid-MEM_WAIT restarts in RUN. Memory re-request is the memory's responsibility.

## Test plan
- Load r3 in EX, decode reads r3 (useA_d=1) -> one cycle stallF=stallD=flushE=1, stallCount=1. Repeat with dstReg_e=0 -> no stall.
- mispredict_e for one cycle, IMEM_LAT=1 -> cycle0 flushD=flushE=1, cycle1 flushD=1 state=2, cycle2 state=0, flushCount=1.
- memReq_m=1 with memAck low 3 cycles then high -> stallF/D/E/M=flushW=1 for 3 cycles, state=1, outputs 0 on ack cycle, stallCount=3.
- memWait and mispredict_e in the same cycle -> MEM_WAIT stalls only. After ack, next cycle flushD=flushE=1 and flushCount=1.
- memWait during REDIRECT with IMEM_LAT=3 -> redirCnt frozen, returns to REDIRECT, total flushD-only cycles still 3.
- Assert reset asynchronously mid-MEM_WAIT -> state=0, counters=0, outputs 0 immediately. Also preload stallCount to max-1 (CNTBITS=4) and check it saturates at 15.
